// File: rtl/ula_timing_pkg.sv
// Raster timing constants per machine mode and the contention window geometry.
// Pure declarations; no state.
// No flow control; consumed combinationally by the raster and contention logic.
package ula_timing_pkg;

  typedef enum logic [1:0] {
    MODE_48K  = 2'd0,
    MODE_128K = 2'd1,
    MODE_PENT = 2'd2
  } mode_e;

  typedef struct packed {
    logic [8:0] htotal;
    logic [8:0] vtotal;
    logic [8:0] int_vc;
    logic [8:0] int_hc;
    logic [6:0] int_len;
  } timing_t;

  localparam int PHASE_LIMIT = 12;
  localparam int WIN_WIDTH   = 256;

  localparam timing_t T_48K  = '{htotal: 9'd448, vtotal: 9'd312, int_vc: 9'd248, int_hc: 9'd0,   int_len: 7'd64};
  localparam timing_t T_128K = '{htotal: 9'd456, vtotal: 9'd311, int_vc: 9'd248, int_hc: 9'd4,   int_len: 7'd72};
  localparam timing_t T_PENT = '{htotal: 9'd448, vtotal: 9'd320, int_vc: 9'd239, int_hc: 9'd320, int_len: 7'd64};

  // Encoding 11 has no machine of its own and runs as a 48K.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_128K;
      2'b10:   return MODE_PENT;
      default: return MODE_48K;
    endcase
  endfunction

  function automatic timing_t mode_timing(input mode_e m);
    case (m)
      MODE_128K: return T_128K;
      MODE_PENT: return T_PENT;
      default:   return T_48K;
    endcase
  endfunction

endpackage

// File: rtl/ula_raster_counter.sv
// Horizontal/vertical pixel counters; machine mode is latched only at reset and frame wrap.
// Latency: counters update on the clk7en edge they are enabled on.
// No backpressure; everything holds while clk7en is low.
module ula_raster_counter
  import ula_timing_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clk7en,
  input  logic [1:0] timing_mode,
  output logic [8:0] hc,
  output logic [8:0] vc,
  output mode_e      mode_q
);

  timing_t t;
  logic    h_end;
  logic    v_end;
  logic    unused_timing;

  assign t     = mode_timing(mode_q);
  assign h_end = (hc == t.htotal - 9'd1);
  assign v_end = (vc == t.vtotal - 9'd1);
  assign unused_timing = ^{t.int_vc, t.int_hc, t.int_len};

  always_ff @(posedge clk) begin
    if (rst) begin
      hc     <= '0;
      vc     <= '0;
      mode_q <= decode_mode(timing_mode);
    end else if (clk7en) begin
      if (h_end) begin
        hc <= '0;
        if (v_end) begin
          vc     <= '0;
          mode_q <= decode_mode(timing_mode);
        end else begin
          vc <= vc + 9'd1;
        end
      end else begin
        hc <= hc + 9'd1;
      end
    end
  end

endmodule

// File: rtl/ula_contention_gen.sv
// ULA raster timing, CPU memory/IO contention request and frame interrupt.
// Latency: cpu_contention reflects bus/hc one clk7en earlier; IO term enabled by ULA_IO_CONTENTION_EN.
// No backpressure; bus sampled only on clk7en, all registers hold while it is low.
module ula_contention_gen
  import ula_timing_pkg::*;
#(
  parameter int CONT_HSTART = 0,
  parameter int PAPER_LINES = 192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk7en,
  input  logic [1:0]  timing_mode,
  input  logic [15:0] a,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        bank_contended,
  output logic [8:0]  hc,
  output logic [8:0]  vc,
  output logic        int_n,
  output logic        cpu_contention
);

  mode_e      mode_q;
  timing_t    t;
  logic [8:0] hrel;
  logic [3:0] ph;
  logic       win;
  logic       ph_ok;
  logic       mem_acc;
  logic       io_acc;
  logic [6:0] int_cnt;
  logic       unused_bits;

  ula_raster_counter u_raster (
    .clk         (clk),
    .rst         (rst),
    .clk7en      (clk7en),
    .timing_mode (timing_mode),
    .hc          (hc),
    .vc          (vc),
    .mode_q      (mode_q)
  );

  assign t     = mode_timing(mode_q);
  assign hrel  = hc - 9'(CONT_HSTART);
  assign ph    = hrel[3:0];
  // hc below the window start must not alias into it through the subtraction.
  assign win   = (vc < 9'(PAPER_LINES)) && (hc >= 9'(CONT_HSTART)) && (hrel < 9'(WIN_WIDTH));
  assign ph_ok = (ph < 4'(PHASE_LIMIT));

  assign mem_acc = !mreq_n &&
                   ((a[15:14] == 2'b01) ||
                    ((a[15:14] == 2'b11) && bank_contended && (mode_q == MODE_128K)));

`ifdef ULA_IO_CONTENTION_EN
  assign io_acc      = !iorq_n && (!a[0] || (a[15:14] == 2'b01));
  assign unused_bits = ^{a[13:1], t.htotal, t.vtotal};
`else
  assign io_acc      = 1'b0;
  assign unused_bits = ^{a[13:0], iorq_n, t.htotal, t.vtotal};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_contention <= 1'b0;
      int_n          <= 1'b1;
      int_cnt        <= '0;
    end else if (clk7en) begin
      cpu_contention <= (mode_q != MODE_PENT) && win && ph_ok && (mem_acc || io_acc);
      // A running pulse blocks retrigger until its count is exhausted.
      if (int_cnt != 7'd0) begin
        int_cnt <= int_cnt - 7'd1;
        if (int_cnt == 7'd1) int_n <= 1'b1;
      end else if ((vc == t.int_vc) && (hc == t.int_hc)) begin
        int_n   <= 1'b0;
        int_cnt <= t.int_len;
      end
    end
  end

endmodule
